transmitter: RTL
================

Name: transmitter

Overview:
- Send side of the inter-board audio link.
- Takes 18-bit left/right codec samples on a one-cycle sample strobe.
- Rounds and saturates each sample to 12 bits.
- Drives the 12-bit words on parallel outputs, framed by a `tx_ready` strobe. The far-end receiver latches data on the falling edge of `tx_ready`.
- Absorbs one sample of jitter with a single-entry pending buffer and flags lost samples.

Parameters:
- `SETUP_CYCLES`, 4: cycles data is stable with `tx_ready` low before the rising edge.
- `HIGH_CYCLES`, 8: cycles `tx_ready` stays high.
- `HOLD_CYCLES`, 4: cycles data is held stable after the falling edge.

Ports:
- `clock_in` input 1: system clock; all logic on posedge.
- `reset` input 1: synchronous, active-high.
- `ready_in` input 1: one-cycle strobe; `l_audio_in`/`r_audio_in` are valid this cycle.
- `l_audio_in` input 18: left sample, two's complement.
- `r_audio_in` input 18: right sample, two's complement.
- `l_audio_out` output 12: left link word, registered.
- `r_audio_out` output 12: right link word, registered.
- `tx_ready` output 1: link strobe; falling edge = data valid at receiver.
- `busy` output 1: high while a frame is in progress (SETUP/HIGH/HOLD).
- `overrun` output 1: one-cycle pulse when a pending sample is overwritten.

Behaviour:
- Reset (synchronous, takes priority in any state, including mid-frame):
  - state=IDLE, all outputs 0, pending buffer empty, counters 0.
  - Aborting from HIGH produces a falling `tx_ready` edge with data 0. This is accepted; the receiver is reset by the same line.
- Rounding, per channel:
  - r = in[17:6] + in[5] (round half up).
  - If in[17:6]==12'h7FF and in[5]==1, r = 12'h7FF (positive saturation).
  - Negative values cannot overflow.
- FSM states are IDLE, SETUP, HIGH, HOLD. A single down-counter is loaded on each state entry.
- IDLE:
  - `busy`=0, `tx_ready`=0, outputs hold the last frame's data.
  - `ready_in`=1 → load rounded data into `l_audio_out`/`r_audio_out` at the next edge and enter SETUP.
- Latency: with `ready_in` at cycle t, new data appears at t+1.
- SETUP: `busy`=1, `tx_ready`=0, for SETUP_CYCLES cycles (t+1..t+S). Then HIGH.
- HIGH: `tx_ready`=1 for HIGH_CYCLES cycles (t+S+1..t+S+H). Then HOLD.
- HOLD: `tx_ready`=0 for HOLD_CYCLES cycles (t+S+H+1..t+S+H+D). Data is unchanged.
- After the last HOLD cycle:
  - If the pending buffer is valid, load its data, clear the buffer, and go straight to SETUP. `busy` stays 1 and there is no IDLE cycle.
  - If the pending buffer is empty and `ready_in`=1 that cycle, load the input directly into SETUP.
  - Otherwise go to IDLE.
  - If the buffer is valid and `ready_in`=1 in the same cycle, send the pending data and store the new sample in the buffer (no overrun).
- Frame length is S+H+D cycles (16 at defaults).
- `ready_in` while `busy` (other than the case above):
  - The rounded sample is written to the pending buffer.
  - If the buffer was already valid, the older entry is overwritten with the newest and `overrun` pulses for exactly one cycle, the cycle after the strobe.
- Data outputs change only on the load edge into SETUP, never in HIGH or HOLD.
- `tx_ready` is glitch-free (registered).
- `ready_in` asserted for multiple consecutive cycles is treated as one sample per asserted cycle.

Test Plan:
- Reset, then `ready_in` pulse at cycle 10 with l=18'h00040, r=18'h3FFC0 → cycle 11: `l_audio_out`=12'h001, `r_audio_out`=12'hFFF, `busy`=1. `tx_ready` high cycles 15..22, low at 23. `busy` low from cycle 27.
- Rounding/saturation, one frame each: in 18'h1FFE0→12'h7FF; 18'h00020→12'h001; 18'h0001F→12'h000; 18'h3FFE0→12'h000; 18'h20000→12'h800.
- Back-to-back: second `ready_in` at cycle 14 (A=18'h01000, B=18'h02000) → frame A completes; B loads at cycle 27 (value 12'h080), no IDLE cycle, `tx_ready` rises at 31, `overrun` never asserts.
- Three strobes during one frame (cycles 12, 14, 16) → `overrun` pulses at cycle 17 only. The second frame carries the cycle-16 sample; the cycle-14 sample is never driven.
- Reset at cycle 18 (mid-HIGH) → cycle 19: `tx_ready`=0, outputs 0, `busy`=0. A new `ready_in` at cycle 20 starts a clean frame with `tx_ready` rising at cycle 25.
- Hold stability: during SETUP/HIGH/HOLD, toggle `l_audio_in`/`r_audio_in` every cycle with `ready_in`=0 → `l_audio_out`/`r_audio_out` constant for the whole frame.

Source files
------------

// File: rtl/transmitter.sv
// transmitter: send side of the inter-board audio link.
// Rounds/saturates 18-bit left/right samples to 12 bits and presents them on
// parallel outputs framed by tx_ready (SETUP low, HIGH high, HOLD low). The far
// end latches data on the falling edge of tx_ready. A single-entry pending
// buffer absorbs one sample of jitter; overwriting it pulses overrun.
//
// Ports:
//   clock_in     in   system clock, posedge
//   reset        in   synchronous, active-high
//   ready_in     in   one-cycle sample strobe
//   l_audio_in   in   [17:0] left sample, two's complement
//   r_audio_in   in   [17:0] right sample, two's complement
//   l_audio_out  out  [11:0] left link word (registered)
//   r_audio_out  out  [11:0] right link word (registered)
//   tx_ready     out  link strobe (registered)
//   busy         out  frame in progress (registered)
//   overrun      out  one-cycle pulse when a pending sample is overwritten
module transmitter #(
    parameter int unsigned SETUP_CYCLES = 4,
    parameter int unsigned HIGH_CYCLES  = 8,
    parameter int unsigned HOLD_CYCLES  = 4
) (
    input  logic        clock_in,
    input  logic        reset,
    input  logic        ready_in,
    input  logic [17:0] l_audio_in,
    input  logic [17:0] r_audio_in,
    output logic [11:0] l_audio_out,
    output logic [11:0] r_audio_out,
    output logic        tx_ready,
    output logic        busy,
    output logic        overrun
);

    localparam int unsigned IN_W    = 18;
    localparam int unsigned OUT_W   = 12;
    localparam int unsigned MAX_SH  = (SETUP_CYCLES > HIGH_CYCLES) ? SETUP_CYCLES : HIGH_CYCLES;
    localparam int unsigned MAX_CYC = (MAX_SH > HOLD_CYCLES) ? MAX_SH : HOLD_CYCLES;
    localparam int unsigned CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_HIGH  = 2'd2,
        ST_HOLD  = 2'd3
    } state_e;

    // Round half up on bit 5; the only overflow case is the top positive code.
    function automatic logic [OUT_W-1:0] round_sat(input logic [IN_W-1:0] x);
        logic [OUT_W-1:0] t;
        t = x[IN_W-1:IN_W-OUT_W];
        if ((t == 12'h7FF) && x[5]) begin
            return 12'h7FF;
        end
        return t + OUT_W'(x[5]);
    endfunction

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic [OUT_W-1:0]   l_out_q, l_out_d;
    logic [OUT_W-1:0]   r_out_q, r_out_d;
    logic [OUT_W-1:0]   pend_l_q, pend_l_d;
    logic [OUT_W-1:0]   pend_r_q, pend_r_d;
    logic               pend_valid_q, pend_valid_d;
    logic               overrun_q, overrun_d;
    logic               tx_ready_q, tx_ready_d;
    logic               busy_q, busy_d;

    logic [OUT_W-1:0]   l_rnd, r_rnd;
    logic               frame_end;
    logic               load_pend;
    logic               load_in;
    logic               write_pend;

    assign l_rnd     = round_sat(l_audio_in);
    assign r_rnd     = round_sat(r_audio_in);
    assign frame_end = (state_q == ST_HOLD) && (cnt_q == '0);

    // State register
    always_ff @(posedge clock_in) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state: down-counter reloaded with (length-1) on each state entry
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            ST_IDLE: begin
                if (ready_in) begin
                    state_d = ST_SETUP;
                    cnt_d   = CNT_W'(SETUP_CYCLES - 1);
                end
            end
            ST_SETUP: begin
                if (cnt_q == '0) begin
                    state_d = ST_HIGH;
                    cnt_d   = CNT_W'(HIGH_CYCLES - 1);
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_HIGH: begin
                if (cnt_q == '0) begin
                    state_d = ST_HOLD;
                    cnt_d   = CNT_W'(HOLD_CYCLES - 1);
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_HOLD: begin
                if (cnt_q == '0) begin
                    if (pend_valid_q || ready_in) begin
                        state_d = ST_SETUP;
                        cnt_d   = CNT_W'(SETUP_CYCLES - 1);
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Output / datapath next values
    always_comb begin
        l_out_d      = l_out_q;
        r_out_d      = r_out_q;
        pend_l_d     = pend_l_q;
        pend_r_d     = pend_r_q;
        pend_valid_d = pend_valid_q;
        overrun_d    = 1'b0;

        // Pending data always wins at frame end; a same-cycle strobe refills the buffer.
        load_pend  = frame_end && pend_valid_q;
        load_in    = ready_in && ((state_q == ST_IDLE) || (frame_end && !pend_valid_q));
        write_pend = ready_in && (state_q != ST_IDLE) && !load_in;

        if (load_pend) begin
            l_out_d      = pend_l_q;
            r_out_d      = pend_r_q;
            pend_valid_d = 1'b0;
        end else if (load_in) begin
            l_out_d = l_rnd;
            r_out_d = r_rnd;
        end

        if (write_pend) begin
            pend_l_d     = l_rnd;
            pend_r_d     = r_rnd;
            pend_valid_d = 1'b1;
            // Refilling the just-drained slot at frame end is not a loss.
            overrun_d    = pend_valid_q && !frame_end;
        end

        tx_ready_d = (state_d == ST_HIGH);
        busy_d     = (state_d != ST_IDLE);
    end

    // Datapath and output registers
    always_ff @(posedge clock_in) begin
        if (reset) begin
            l_out_q      <= '0;
            r_out_q      <= '0;
            pend_l_q     <= '0;
            pend_r_q     <= '0;
            pend_valid_q <= 1'b0;
            overrun_q    <= 1'b0;
            tx_ready_q   <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            l_out_q      <= l_out_d;
            r_out_q      <= r_out_d;
            pend_l_q     <= pend_l_d;
            pend_r_q     <= pend_r_d;
            pend_valid_q <= pend_valid_d;
            overrun_q    <= overrun_d;
            tx_ready_q   <= tx_ready_d;
            busy_q       <= busy_d;
        end
    end

    assign l_audio_out = l_out_q;
    assign r_audio_out = r_out_q;
    assign tx_ready    = tx_ready_q;
    assign busy        = busy_q;
    assign overrun     = overrun_q;

endmodule
